// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver (idle-high, start, Data_width data bits
// LSB first, optional parity, one stop bit). Prescale clocks per bit.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority vote per bit
// instead of a single mid-bit sample.
module uart_rx #(
    parameter int unsigned Data_width = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            Prescale,
    output logic [Data_width-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int unsigned BIT_W = (Data_width > 1) ? $clog2(Data_width) : 1;
    localparam int unsigned CNT_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                  state_q, state_d;
    logic                    rx_meta_q, rx_meta_d;
    logic                    rx_s_q, rx_s_d;
    logic [CNT_W-1:0]        edge_cnt_q, edge_cnt_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [Data_width-1:0]   shift_q, shift_d;
    logic                    par_en_q, par_en_d;
    logic                    par_typ_q, par_typ_d;
    logic [CNT_W-1:0]        presc_q, presc_d;
    logic [Data_width-1:0]   p_data_q, p_data_d;
    logic                    data_valid_q, data_valid_d;
    logic                    par_err_q, par_err_d;
    logic                    stp_err_q, stp_err_d;

    logic                    bit_val_c;
    logic                    at_mid_c;
    logic                    at_end_c;
    logic [CNT_W-1:0]        half_c;
    logic [CNT_W-1:0]        last_c;

    // Two-flop synchroniser for the asynchronous serial line
    always_comb begin
        rx_meta_d = RX_IN;
        rx_s_d    = rx_meta_q;
    end

    // Bit decision points derived from the frame's latched prescale
    assign half_c   = presc_q >> 1;
    assign last_c   = presc_q - CNT_W'(1);
    assign at_mid_c = (edge_cnt_q == half_c);
    assign at_end_c = (edge_cnt_q == last_c);

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] smp_q, smp_d;

    // History of the two previous rx_s samples for the majority vote
    always_comb begin
        smp_d = {smp_q[0], rx_s_q};
    end

    // Sample history register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            smp_q <= 2'b11;
        end else begin
            smp_q <= smp_d;
        end
    end

    assign bit_val_c = (smp_q[1] & smp_q[0]) | (smp_q[1] & rx_s_q) | (smp_q[0] & rx_s_q);
`else
    assign bit_val_c = rx_s_q;
`endif

    // Frame FSM: next state, counters, shift register and output updates
    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = edge_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        presc_d      = presc_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = par_err_q;
        stp_err_d    = stp_err_q;

        if (state_q != ST_IDLE) begin
            edge_cnt_d = at_end_c ? '0 : edge_cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                edge_cnt_d = '0;
                if (!rx_s_q) begin
                    // Detecting cycle is edge 0 of the start bit
                    state_d    = ST_START;
                    edge_cnt_d = CNT_W'(1);
                    bit_cnt_d  = '0;
                    par_err_d  = 1'b0;
                    stp_err_d  = 1'b0;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    presc_d    = Prescale;
                end
            end
            ST_START: begin
                if (at_mid_c && bit_val_c) begin
                    state_d    = ST_IDLE;
                    edge_cnt_d = '0;
                end else if (at_end_c) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (at_mid_c) begin
                    shift_d = {bit_val_c, shift_q[Data_width-1:1]};
                end
                if (at_end_c) begin
                    if (bit_cnt_q == BIT_W'(Data_width - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (at_mid_c && (bit_val_c != ((^shift_q) ^ par_typ_q))) begin
                    par_err_d = 1'b1;
                end
                if (at_end_c) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (at_mid_c && !bit_val_c) begin
                    stp_err_d = 1'b1;
                end
                if (at_end_c) begin
                    state_d = ST_IDLE;
                    if (!par_err_q && !stp_err_q) begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            presc_q      <= '0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_meta_q    <= rx_meta_d;
            rx_s_q       <= rx_s_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            presc_q      <= presc_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

Oversampling UART receiver, the receive-side counterpart of the team's UART transmitter. It converts the serial line back into a parallel word.

- Line format is identical to the transmitter: idle-high, start bit, `Data_width` data bits LSB first, optional parity bit, one stop bit.
- Each bit period is `Prescale` clock cycles.
- The block checks start, parity and stop bits and presents the word with a one-cycle valid strobe.
- It sits between the pad-side serial input and the system's register/command layer.

## Interface
- `Data_width`, 8, number of data bits per frame.
- `CLK` input 1: single clock; oversampling clock, `Prescale` cycles per bit.
- `RST` input 1: asynchronous, active-high reset.
- `RX_IN` input 1: serial line, asynchronous to `CLK`, idle high.
- `PAR_EN` input 1: 1 = frame carries a parity bit.
- `PAR_TYP` input 1: 0 = even parity, 1 = odd parity.
- `Prescale` input 6: cycles per bit. Legal values are 8, 16 and 32; any other value is undefined.
- `P_DATA` output `Data_width`: last correctly received word.
- `data_valid` output 1: one-cycle strobe; `P_DATA` is new.
- `par_err` output 1: parity mismatch in the current/last frame.
- `stp_err` output 1: stop bit sampled low in the current/last frame.

## Operation
**Input synchronisation**
- `RX_IN` passes through a 2-flop synchroniser, reset value 1. All behaviour below refers to the synchronised signal `rx_s`.

**Counters**
- `edge_cnt` counts 0..`Prescale`-1 within a bit and wraps to 0 at each bit boundary.
- `bit_cnt` counts data bits, 0..`Data_width`-1.

**Configuration latch**
- `PAR_EN`, `PAR_TYP` and `Prescale` are captured when a start bit is detected.
- The captured values are held for the whole frame. Changes mid-frame affect the next frame only.

**Sampling**
- Bit value is decided at `edge_cnt` == `Prescale`/2. Sample sources are defined under Configuration.

**FSM states**
- IDLE: `rx_s`=0 → START. The detecting cycle counts as `edge_cnt`=0; `par_err` and `stp_err` clear.
- START: at the decision point, sampled 1 → glitch, return to IDLE with no flags set. Sampled 0 → continue; at `edge_cnt`=`Prescale`-1 → DATA.
- DATA: each decided bit is shifted into a shift register, LSB first. After bit `Data_width`-1 completes → PARITY if `PAR_EN`=1, otherwise STOP.
- PARITY: at the decision point, compare against the XOR of the data bits, inverted when `PAR_TYP`=1. A mismatch sets `par_err`=1. At end of bit → STOP.
- STOP: at the decision point, sampled 0 → `stp_err`=1. At `edge_cnt`=`Prescale`-1 → IDLE.
  - If neither error is set: load `P_DATA` from the shift register and assert `data_valid` for that single next cycle.
  - If either error is set: `P_DATA` is unchanged and `data_valid` stays 0.

**Boundary cases**
- Back-to-back frames: IDLE samples `rx_s` in the same cycle it is entered, so a start bit immediately following the stop bit is accepted with no gap.
- Reset mid-frame: every output and all state return to reset values immediately. The partial frame is discarded and produces no `data_valid`.

## Timing
- Reset values: `P_DATA`=0, `data_valid`=0, `par_err`=0, `stp_err`=0, state IDLE, counters 0.
- Frame length is (2 + `Data_width` + `PAR_EN`) × `Prescale` cycles, measured from the first `rx_s`=0 cycle.
- `data_valid` rises in the cycle after the last stop-bit cycle. Relative to `RX_IN`, add 2 cycles of synchroniser latency.
- `par_err` and `stp_err` are registered one cycle after their decision point. They are held until the next start detection.
- All outputs are registered.

## Configuration
- Macro: `UART_RX_MAJORITY_EN`.
- Defined:
  - Each bit is the 2-of-3 majority of `rx_s` sampled at `edge_cnt` = `Prescale`/2-2, `Prescale`/2-1 and `Prescale`/2.
  - The decision is taken at the end of the `Prescale`/2 cycle.
  - A single-cycle glitch on any bit does not alter the result.
- Undefined:
  - Single sample of `rx_s` at `edge_cnt` = `Prescale`/2.
  - The sampling registers are not built.
- All other timing is identical in both builds.

## Test plan
- `Prescale`=8, `PAR_EN`=1, `PAR_TYP`=0, frame 0xA5 with parity bit 0 → one-cycle `data_valid`, `P_DATA`=0xA5, `par_err`=0, `stp_err`=0.
- Same frame with `PAR_TYP`=1, parity bit sent as 0 → `par_err`=1, no `data_valid`, `P_DATA` keeps its previous value.
- `Prescale`=16, `PAR_EN`=0, 0x3C sent with stop bit 0 → `stp_err`=1, no `data_valid`. Next frame 0xC3, sent correctly → `stp_err` clears at its start bit, `data_valid`, `P_DATA`=0xC3.
- `Prescale`=8, `RX_IN` low for 2 cycles then high → FSM returns to IDLE, no flags. A following valid 0x5A frame is received correctly.
- `Prescale`=16, frames 0x01 and 0xFE back-to-back with no idle gap → two `data_valid` pulses exactly 160 cycles apart, `P_DATA`=0x01 then 0xFE.
- `RST` asserted during DATA bit 3 of 0x77, `Prescale`=32 → all outputs 0 immediately. A full 0x77 frame after release → `data_valid`, `P_DATA`=0x77.
